// File: rtl/cube_frame_scheduler.sv
// Double-buffered 8x8x8 LED cube frame store: assembles 64-byte frames from a byte
// stream and scans the front frame onto the layer/latch/data buses one layer at a time.
module cube_frame_scheduler #(
    parameter int unsigned DWELL_CYCLES = 5000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hF0,
    parameter int unsigned RX_TIMEOUT   = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] layers_out,
    output logic [7:0] latches_out,
    output logic [7:0] data_out,
    output logic       frame_swap,
    output logic       frame_drop,
    output logic       pending
);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RX_TIMEOUT - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic {
        RX_IDLE,
        RX_FILL
    } rx_state_t;

    typedef enum logic [2:0] {
        SC_BLANK,
        SC_SETUP,
        SC_STROBE,
        SC_HOLD,
        SC_ON
    } scan_state_t;

    // Receive side
    rx_state_t       rx_state_reg;
    logic [5:0]      cnt_reg;
    logic [TW-1:0]   timer_reg;
    logic            pending_reg;
    logic            frame_drop_reg;

    // Scan side
    scan_state_t     scan_state_reg;
    logic [2:0]      layer_reg;
    logic [2:0]      row_reg;
    logic [DW-1:0]   dwell_reg;
    logic            front_sel_reg;
    logic            front_blank_reg;
    logic [7:0]      layers_reg;
    logic [7:0]      latches_reg;
    logic [7:0]      data_reg;
    logic            frame_swap_reg;

    // Both buffers share one RAM; the top address bit selects the buffer.
    logic [7:0]      frame_mem [0:127];
    logic [7:0]      rd_data_reg;
    logic [6:0]      wr_addr;
    logic [6:0]      rd_addr;
    logic [2:0]      rd_row;
    logic            wr_en;
    logic            frame_done;
    logic            swap_now;
    logic [7:0]      layer_onehot;
    logic [7:0]      row_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign layer_onehot[gi] = (layer_reg == 3'(gi));
            assign row_onehot[gi]   = (row_reg == 3'(gi));
        end
    endgenerate

    assign wr_en      = (rx_state_reg == RX_FILL) && rx_valid;
    assign frame_done = wr_en && (cnt_reg == 6'd63);
    assign wr_addr    = {~front_sel_reg, cnt_reg};
    assign swap_now   = (scan_state_reg == SC_ON) && (layer_reg == 3'd7) &&
                        (dwell_reg == DWELL_LAST) && pending_reg;

    // Read one cycle ahead of SETUP: during HOLD the row counter still names the old row.
    assign rd_row  = (scan_state_reg == SC_HOLD) ? row_reg + 3'd1 : row_reg;
    assign rd_addr = {front_sel_reg, layer_reg, rd_row};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_mem[wr_addr] <= rx_data;
        end
        rd_data_reg <= frame_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg   <= RX_IDLE;
            cnt_reg        <= 6'd0;
            timer_reg      <= '0;
            pending_reg    <= 1'b0;
            frame_drop_reg <= 1'b0;
        end else begin
            frame_drop_reg <= 1'b0;
            // A frame cannot complete while one is pending, so set and clear never collide.
            if (swap_now) begin
                pending_reg <= 1'b0;
            end else if (frame_done) begin
                pending_reg <= 1'b1;
            end
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        if (pending_reg) begin
                            frame_drop_reg <= 1'b1;
                        end else begin
                            rx_state_reg <= RX_FILL;
                            cnt_reg      <= 6'd0;
                            timer_reg    <= '0;
                        end
                    end
                end
                RX_FILL: begin
                    if (rx_valid) begin
                        cnt_reg   <= cnt_reg + 6'd1;
                        timer_reg <= '0;
                        if (cnt_reg == 6'd63) begin
                            rx_state_reg <= RX_IDLE;
                        end
                    end else if (timer_reg == TIMER_LAST) begin
                        rx_state_reg   <= RX_IDLE;
                        frame_drop_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_state_reg  <= SC_BLANK;
            layer_reg       <= 3'd0;
            row_reg         <= 3'd0;
            dwell_reg       <= '0;
            front_sel_reg   <= 1'b0;
            front_blank_reg <= 1'b1;
            layers_reg      <= 8'd0;
            latches_reg     <= 8'd0;
            data_reg        <= 8'd0;
            frame_swap_reg  <= 1'b0;
        end else begin
            frame_swap_reg <= swap_now;
            layers_reg     <= (scan_state_reg == SC_ON) ? layer_onehot : 8'd0;
            latches_reg    <= (scan_state_reg == SC_STROBE) ? row_onehot : 8'd0;
            case (scan_state_reg)
                SC_BLANK: begin
                    scan_state_reg <= SC_SETUP;
                end
                SC_SETUP: begin
                    // Front buffer reads as zero until the first frame has been swapped in.
                    data_reg       <= front_blank_reg ? 8'd0 : rd_data_reg;
                    scan_state_reg <= SC_STROBE;
                end
                SC_STROBE: begin
                    scan_state_reg <= SC_HOLD;
                end
                SC_HOLD: begin
                    row_reg        <= row_reg + 3'd1;
                    dwell_reg      <= '0;
                    scan_state_reg <= (row_reg == 3'd7) ? SC_ON : SC_SETUP;
                end
                SC_ON: begin
                    if (dwell_reg == DWELL_LAST) begin
                        layer_reg      <= layer_reg + 3'd1;
                        scan_state_reg <= SC_BLANK;
                        if (swap_now) begin
                            front_sel_reg   <= ~front_sel_reg;
                            front_blank_reg <= 1'b0;
                        end
                    end else begin
                        dwell_reg <= dwell_reg + DW'(1);
                    end
                end
                default: scan_state_reg <= SC_BLANK;
            endcase
        end
    end

    assign layers_out  = layers_reg;
    assign latches_out = latches_reg;
    assign data_out    = data_reg;
    assign frame_swap  = frame_swap_reg;
    assign frame_drop  = frame_drop_reg;
    assign pending     = pending_reg;

endmodule

// File: doc/cube_frame_scheduler.md
# cube_frame_scheduler

Double-buffered frame store and scan sequencer for the 8x8x8 LED cube. It sits between the UART byte stream and the GPIO cube pins: it assembles 64-byte frames from received bytes, then time-multiplexes the front frame onto the layer, latch-strobe and data buses one layer at a time. A completed frame is swapped in only at a full-scan boundary, so a partially drawn frame is never displayed.

## Interface
- DWELL_CYCLES, 5000: cycles a layer is lit per scan slot; legal range ≥1.
- SYNC_BYTE, 8'hF0: frame start marker, recognised only while waiting for a frame.
- RX_TIMEOUT, 65535: idle cycles allowed between bytes inside a frame before the frame is aborted; legal range ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_data  in  8  received byte.
- layers_out  out  8  layer enables, active-high, at most one bit set.
- latches_out  out  8  row latch strobes, active-high, at most one bit set.
- data_out  out  8  column data for the row being latched.
- frame_swap  out  1  one-cycle pulse when the back buffer becomes the front buffer.
- frame_drop  out  1  one-cycle pulse when a frame is rejected or aborted.
- pending  out  1  a complete frame is waiting for the next swap.

## Operation
- Storage: two 64-byte buffers and a front_sel bit. Byte index = layer*8 + row. Bit c of a byte drives data_out[c].
- Receive FSM, RX_IDLE:
  - rx_valid with rx_data==SYNC_BYTE and pending==0: go to RX_FILL, clear cnt and the idle timer.
  - SYNC_BYTE with pending==1: stay in RX_IDLE and pulse frame_drop.
  - Any other byte: ignored.
- Receive FSM, RX_FILL:
  - Every rx_valid writes rx_data to back[cnt] and increments cnt. All 8-bit values are data here, including SYNC_BYTE.
  - The write with cnt==63 sets pending and returns to RX_IDLE.
  - The idle timer counts cycles without rx_valid and resets on each rx_valid. When it reaches RX_TIMEOUT: return to RX_IDLE, pulse frame_drop, leave pending unchanged.
- Scan FSM: layer counter L (0..7) and row counter r (0..7). Phases per layer:
  - BLANK, 1 cycle: layers_out=0, latches_out=0.
  - SETUP, 1 cycle: data_out=front[L*8+r], latches_out=0.
  - STROBE, 1 cycle: latches_out=1<<r, data_out held.
  - HOLD, 1 cycle: latches_out=0, data_out held. Then r++. After r==7 go to ON, otherwise go to SETUP.
  - ON, DWELL_CYCLES cycles: layers_out=1<<L, latches_out=0, data_out held. Then L++ (7 wraps to 0) and go to BLANK.
- Swap: in the last ON cycle of L==7, if pending==1 (registered value), toggle front_sel and clear pending. frame_swap is high the following cycle.
- Simultaneous events:
  - A frame completes in the same cycle as the swap check: the old pending==0 is used, so the swap waits one full scan.
  - A frame completes and the scan is at any other point: no interaction.
- Reset, including mid-frame or mid-scan: both FSMs go idle, all counters clear, front_sel=0, the front buffer is cleared to zero, pending=0. The back buffer contents are don't-care.

## Timing
- Reset values: layers_out=0, latches_out=0, data_out=0, frame_swap=0, frame_drop=0, pending=0. After release, the scan starts at BLANK, L=0.
- All outputs are registered.
- rx_valid with the 64th byte sets pending in the next cycle.
- Layer slot = 1 + 8*3 + DWELL_CYCLES cycles. Full scan = 8 × slot.
- Maximum latency from pending rising to frame_swap is one full scan plus 1 cycle.
- Invariant: layers_out is zero in every cycle where latches_out is nonzero.
- rx_valid has no backpressure and is accepted on every cycle; there is no minimum spacing.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: all outputs 0.
  - Required: the first nonzero layers_out is 8'h01, starting at cycle 26 after release (cycle 0 = first cycle after release; BLANK = cycle 0, 8×3 row cycles = cycles 1..24, ON starts the cycle after), with DWELL_CYCLES=4.
- Basic frame:
  - Stimulus: SYNC, then bytes k=0..63 with value k.
  - Required: pending rises.
  - Required: frame_swap pulses once after the layer-7 ON phase.
  - Required: on the next scan, the STROBE for L=2, r=5 shows data_out=8'd21 and latches_out=8'h20.
- SYNC as data: a frame whose byte 10 is 8'hF0 completes normally, and front[10]=8'hF0 after the swap.
- Timeout:
  - Stimulus: SYNC plus 30 bytes, then silence for RX_TIMEOUT cycles (set RX_TIMEOUT=16).
  - Required: frame_drop pulses, pending stays 0, no swap occurs.
  - Required: a following full frame is accepted.
- Pending reject: a second SYNC while pending=1 pulses frame_drop, and the first frame is the one displayed after the swap.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during L=4 ON with a half-received frame.
  - Required: outputs 0, pending=0, the display is dark, and the half frame is discarded.
